// File: rtl/tiny16_pkg.sv
// tiny16 control-path shared definitions: opcodes, control word bit map, FSM states.
package tiny16_pkg;

  // Opcodes, IR[15:12]; 9..D are undefined
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_JC  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Control word bit indices
  localparam int PC_OUT  = 0;
  localparam int PC_INC  = 1;
  localparam int PC_LD   = 2;
  localparam int MAR_LD  = 3;
  localparam int MEM_RD  = 4;
  localparam int MEM_WR  = 5;
  localparam int IR_LD   = 6;
  localparam int A_LD    = 7;
  localparam int B_LD    = 8;
  localparam int A_OUT   = 9;
  localparam int ALU_OUT = 10;
  localparam int ALU_SUB = 11;
  localparam int FLAG_LD = 12;
  localparam int IMM_OUT = 13;
  localparam int OUT_LD  = 14;
  localparam int RSVD    = 15;

  // One-hot masks for building control words
  localparam logic [15:0] C_PC_OUT  = 16'h0001 << PC_OUT;
  localparam logic [15:0] C_PC_INC  = 16'h0001 << PC_INC;
  localparam logic [15:0] C_PC_LD   = 16'h0001 << PC_LD;
  localparam logic [15:0] C_MAR_LD  = 16'h0001 << MAR_LD;
  localparam logic [15:0] C_MEM_RD  = 16'h0001 << MEM_RD;
  localparam logic [15:0] C_MEM_WR  = 16'h0001 << MEM_WR;
  localparam logic [15:0] C_IR_LD   = 16'h0001 << IR_LD;
  localparam logic [15:0] C_A_LD    = 16'h0001 << A_LD;
  localparam logic [15:0] C_B_LD    = 16'h0001 << B_LD;
  localparam logic [15:0] C_A_OUT   = 16'h0001 << A_OUT;
  localparam logic [15:0] C_ALU_OUT = 16'h0001 << ALU_OUT;
  localparam logic [15:0] C_ALU_SUB = 16'h0001 << ALU_SUB;
  localparam logic [15:0] C_FLAG_LD = 16'h0001 << FLAG_LD;
  localparam logic [15:0] C_IMM_OUT = 16'h0001 << IMM_OUT;
  localparam logic [15:0] C_OUT_LD  = 16'h0001 << OUT_LD;

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_RUN     = 2'd1,
    ST_MEMWAIT = 2'd2,
    ST_HALT    = 2'd3
  } state_e;

endpackage

// File: rtl/step_decode.sv
// Microcode ROM: (step, opcode, flags) -> control word plus end-of-instruction info.
module step_decode
  import tiny16_pkg::*;
#(
  parameter int CW_W   = 16,
  parameter int STEP_W = 3
) (
  input  logic [STEP_W-1:0] step,
  input  logic [3:0]        op,
  input  logic              z,
  input  logic              c,
  output logic [CW_W-1:0]   ctrl,
  output logic              last,
  output logic              is_hlt,
  output logic              is_illegal
);

  logic [15:0] w;

  // Table lookup; unlisted (step, op) pairs have no microcode: ctrl=0, end the instruction
  always_comb begin
    w          = '0;
    last       = 1'b0;
    is_hlt     = 1'b0;
    is_illegal = (op >= 4'h9) && (op <= 4'hD);
    case (int'(step))
      0: w = C_PC_OUT | C_MAR_LD;
      1: w = C_MEM_RD | C_IR_LD | C_PC_INC;
      2: begin
        case (op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: w = C_IMM_OUT | C_MAR_LD;
          OP_LDI: begin w = C_IMM_OUT | C_A_LD;  last = 1'b1; end
          OP_JMP: begin w = C_IMM_OUT | C_PC_LD; last = 1'b1; end
          OP_JZ:  begin w = z ? (C_IMM_OUT | C_PC_LD) : 16'h0000; last = 1'b1; end
          OP_JC:  begin w = c ? (C_IMM_OUT | C_PC_LD) : 16'h0000; last = 1'b1; end
          OP_OUT: begin w = C_A_OUT | C_OUT_LD;  last = 1'b1; end
          OP_HLT: is_hlt = 1'b1;
          default: last = 1'b1;  // NOP and undefined opcodes
        endcase
      end
      3: begin
        case (op)
          OP_LDA:         begin w = C_MEM_RD | C_A_LD;  last = 1'b1; end
          OP_ADD, OP_SUB: w = C_MEM_RD | C_B_LD;
          OP_STA:         begin w = C_A_OUT | C_MEM_WR; last = 1'b1; end
          default:        last = 1'b1;
        endcase
      end
      4: begin
        case (op)
          OP_ADD:  w = C_ALU_OUT | C_A_LD | C_FLAG_LD;
          OP_SUB:  w = C_ALU_OUT | C_A_LD | C_FLAG_LD | C_ALU_SUB;
          default: w = '0;
        endcase
        last = 1'b1;
      end
      default: last = 1'b1;
    endcase
  end

  assign ctrl = CW_W'(w);

endmodule

// File: rtl/step_control.sv
// tiny16 control FSM: drives the datapath control word, stalls/clears the step
// counter and counts retired instructions.
module step_control
  import tiny16_pkg::*;
#(
  parameter int CW_W   = 16,
  parameter int CNT_W  = 16,
  parameter int STEP_W = 3
) (
  input  logic              clk,
  input  logic              rst,       // asynchronous, active low
  input  logic [STEP_W-1:0] step,
  input  logic [3:0]        ir_op,
  input  logic              flag_z,
  input  logic              flag_c,
  input  logic              mem_ack,
  input  logic              resume,
  output logic [CW_W-1:0]   ctrl,
  output logic              mem_req,
  output logic              step_clr,
  output logic              step_hold,
  output logic              halted,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired
);

  state_e            state_q, state_d;
  logic [CW_W-1:0]   frz_ctrl_q;
  logic              frz_last_q;
  logic              frz_ld;
  logic [CNT_W-1:0]  retired_q;
  logic              illegal_q, illegal_d;
  logic              retire;

  logic [CW_W-1:0]   dec_ctrl;
  logic              dec_last, dec_hlt, dec_illegal, dec_mem;

  step_decode #(.CW_W(CW_W), .STEP_W(STEP_W)) u_dec (
    .step       (step),
    .op         (ir_op),
    .z          (flag_z),
    .c          (flag_c),
    .ctrl       (dec_ctrl),
    .last       (dec_last),
    .is_hlt     (dec_hlt),
    .is_illegal (dec_illegal)
  );

  assign dec_mem = dec_ctrl[MEM_RD] | dec_ctrl[MEM_WR];

  // Next state and outputs. A memory step that misses its ack parks in MEMWAIT
  // with its word frozen; the end-of-instruction clear is deferred until the ack.
  always_comb begin
    state_d   = state_q;
    ctrl      = '0;
    step_clr  = 1'b0;
    step_hold = 1'b0;
    halted    = 1'b0;
    frz_ld    = 1'b0;
    retire    = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      ST_SYNC: begin
        step_clr = 1'b1;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        ctrl = dec_ctrl;
        if (dec_mem && !mem_ack) begin
          step_hold = 1'b1;
          frz_ld    = 1'b1;
          state_d   = ST_MEMWAIT;
        end else if (dec_hlt) begin
          retire  = 1'b1;
          state_d = ST_HALT;
        end else if (dec_last) begin
          step_clr  = 1'b1;
          retire    = 1'b1;
          illegal_d = dec_illegal;
        end
      end
      ST_MEMWAIT: begin
        ctrl = frz_ctrl_q;
        if (mem_ack) begin
          step_clr = frz_last_q;
          retire   = frz_last_q;
          state_d  = ST_RUN;
        end else begin
          step_hold = 1'b1;
        end
      end
      ST_HALT: begin
        step_hold = 1'b1;
        halted    = 1'b1;
        if (resume) state_d = ST_SYNC;
      end
      default: state_d = ST_SYNC;
    endcase
  end

  assign mem_req = ctrl[MEM_RD] | ctrl[MEM_WR];
  assign illegal = illegal_q;
  assign retired = retired_q;

  // State register; reset forces SYNC so outputs drop without waiting for a clock
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_SYNC;
    else      state_q <= state_d;
  end

  // Capture the word (and its last-step flag) that stalls on memory
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frz_ctrl_q <= '0;
      frz_last_q <= 1'b0;
    end else if (frz_ld) begin
      frz_ctrl_q <= dec_ctrl;
      frz_last_q <= dec_last;
    end
  end

  // Retired-instruction counter (wraps) and one-cycle illegal-opcode pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (retire) retired_q <= retired_q + CNT_W'(1);
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_step_control.sv
// Bench for step_control: a step counter, a configurable memory-ack model, and a
// per-cycle expectation queue built from the instruction-level microcode rules.
module tb_step_control;

  // Control word bits, written out independently of the design package
  localparam logic [15:0] B_PC_OUT  = 16'h0001, B_PC_INC  = 16'h0002, B_PC_LD   = 16'h0004;
  localparam logic [15:0] B_MAR_LD  = 16'h0008, B_MEM_RD  = 16'h0010, B_MEM_WR  = 16'h0020;
  localparam logic [15:0] B_IR_LD   = 16'h0040, B_A_LD    = 16'h0080, B_B_LD    = 16'h0100;
  localparam logic [15:0] B_A_OUT   = 16'h0200, B_ALU_OUT = 16'h0400, B_ALU_SUB = 16'h0800;
  localparam logic [15:0] B_FLAG_LD = 16'h1000, B_IMM_OUT = 16'h2000, B_OUT_LD  = 16'h4000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  step;
  logic [3:0]  ir_op = 4'h0;
  logic        flag_z = 1'b0, flag_c = 1'b0, resume = 1'b0;
  logic        mem_ack;
  logic [15:0] ctrl;
  logic        mem_req, step_clr, step_hold, halted, illegal;
  logic [15:0] retired;

  int ack_delay = 0;
  bit block_wr  = 1'b0;
  int wait_cnt;

  always #5 clk = ~clk;

  step_control #(.CW_W(16), .CNT_W(16), .STEP_W(3)) dut (
    .clk(clk), .rst(rst), .step(step), .ir_op(ir_op), .flag_z(flag_z), .flag_c(flag_c),
    .mem_ack(mem_ack), .resume(resume), .ctrl(ctrl), .mem_req(mem_req), .step_clr(step_clr),
    .step_hold(step_hold), .halted(halted), .illegal(illegal), .retired(retired)
  );

  // Step counter: clear wins over hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           step <= 3'd0;
    else if (step_clr)  step <= 3'd0;
    else if (!step_hold) step <= step + 3'd1;
  end

  // Memory answers after ack_delay cycles of a request; writes can be blocked
  assign mem_ack = mem_req && !(block_wr && ctrl[5]) && (wait_cnt >= ack_delay);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   wait_cnt <= 0;
    else if (!mem_req || mem_ack) wait_cnt <= 0;
    else                        wait_cnt <= wait_cnt + 1;
  end

  typedef struct {
    logic [15:0] ctrl;
    bit          clr, hold, hlt;
    bit [2:0]    step;
    bit          retire, ill;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  int          n_chk = 0, n_fail = 0;
  logic [15:0] m_ret = 16'h0;
  bit          ill_exp = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, want %0h", nm, $time, act, exp);
    end
  endtask

  function automatic void push(logic [15:0] c, bit clr, bit hold, bit hlt, int st, bit ret, bit ill);
    exp_t e;
    e.ctrl = c; e.clr = clr; e.hold = hold; e.hlt = hlt;
    e.step = 3'(st); e.retire = ret; e.ill = ill;
    q.push_back(e);
  endfunction

  function automatic int nsteps(logic [3:0] op);
    case (op)
      4'h1, 4'h4: return 4;
      4'h2, 4'h3: return 5;
      default:    return 3;
    endcase
  endfunction

  // Body word for step k (k >= 2) of an opcode
  function automatic logic [15:0] uw(logic [3:0] op, int k, bit z, bit c);
    logic [15:0] addr;
    addr = B_IMM_OUT | B_MAR_LD;
    case (op)
      4'h1: return (k == 2) ? addr : (B_MEM_RD | B_A_LD);
      4'h2: return (k == 2) ? addr : (k == 3) ? (B_MEM_RD | B_B_LD) : (B_ALU_OUT | B_A_LD | B_FLAG_LD);
      4'h3: return (k == 2) ? addr : (k == 3) ? (B_MEM_RD | B_B_LD)
                                              : (B_ALU_OUT | B_A_LD | B_FLAG_LD | B_ALU_SUB);
      4'h4: return (k == 2) ? addr : (B_A_OUT | B_MEM_WR);
      4'h5: return B_IMM_OUT | B_A_LD;
      4'h6: return B_IMM_OUT | B_PC_LD;
      4'h7: return z ? (B_IMM_OUT | B_PC_LD) : 16'h0;
      4'h8: return c ? (B_IMM_OUT | B_PC_LD) : 16'h0;
      4'hE: return B_A_OUT | B_OUT_LD;
      default: return 16'h0;
    endcase
  endfunction

  // A memory step: d stalled cycles, then the acked cycle carrying any end clear
  function automatic void mem_step(logic [15:0] w, int st, bit last, int d);
    for (int i = 0; i < d; i++) push(w, 1'b0, 1'b1, 1'b0, st, 1'b0, 1'b0);
    push(w, last, 1'b0, 1'b0, st, last, 1'b0);
  endfunction

  function automatic void gen_instr(logic [3:0] op, bit z, bit c, int d);
    int n;
    bit ill, last;
    logic [15:0] w;
    n   = nsteps(op);
    ill = (op >= 4'h9) && (op <= 4'hD);
    push(B_PC_OUT | B_MAR_LD, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    mem_step(B_MEM_RD | B_IR_LD | B_PC_INC, 1, 1'b0, d);
    if (op == 4'hF) begin
      push(16'h0, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0);
      return;
    end
    for (int k = 2; k < n; k++) begin
      w    = uw(op, k, z, c);
      last = (k == n - 1);
      if ((w & (B_MEM_RD | B_MEM_WR)) != 16'h0) mem_step(w, k, last, d);
      else push(w, last, 1'b0, 1'b0, k, last, last && ill);
    end
  endfunction

  // Per-cycle compare against the expectation queue
  always @(negedge clk) begin
    if (rst && q.size() > 0) begin
      cur = q.pop_front();
      chk("ctrl",      32'(ctrl),      32'(cur.ctrl));
      chk("step",      32'(step),      32'(cur.step));
      chk("step_clr",  32'(step_clr),  32'(cur.clr));
      chk("step_hold", 32'(step_hold), 32'(cur.hold));
      chk("halted",    32'(halted),    32'(cur.hlt));
      chk("mem_req",   32'(mem_req),   32'((cur.ctrl & (B_MEM_RD | B_MEM_WR)) != 16'h0));
      chk("illegal",   32'(illegal),   32'(ill_exp));
      chk("retired",   32'(retired),   32'(m_ret));
      if (cur.retire) m_ret = m_ret + 16'h1;
      ill_exp = cur.ill;
    end
  end

  // Returns at posedge+1 of the first cycle after the queue empties
  task automatic wait_drain(output int cyc);
    cyc = 0;
    while (q.size() > 0 && cyc < 300) begin
      @(posedge clk);
      cyc++;
    end
    if (q.size() > 0) begin
      chk("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    #1;
  endtask

  task automatic run_instr(input logic [3:0] op, input bit z, input bit c, input int d, output int cyc);
    ir_op = op; flag_z = z; flag_c = c; ack_delay = d;
    gen_instr(op, z, c, d);
    wait_drain(cyc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    // Reset values
    #12;
    chk("rst_ctrl",      32'(ctrl),      32'h0);
    chk("rst_mem_req",   32'(mem_req),   32'h0);
    chk("rst_step_hold", 32'(step_hold), 32'h0);
    chk("rst_step_clr",  32'(step_clr),  32'h1);
    chk("rst_retired",   32'(retired),   32'h0);
    chk("rst_illegal",   32'(illegal),   32'h0);
    @(posedge clk); #1;

    // 1: release, SYNC, LDI with zero-wait memory
    rst = 1'b1;
    push(16'h0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_instr(4'h5, 1'b0, 1'b0, 0, cyc);
    chk("t1_retired", 32'(retired), 32'd1);
    chk("t1_step",    32'(step),    32'd0);

    // 2: ADD with 3-cycle memory waits on S1 and S3
    run_instr(4'h2, 1'b0, 1'b0, 3, cyc);
    chk("t2_cycles",  32'(cyc),     32'd11);
    chk("t2_retired", 32'(retired), 32'd2);
    run_instr(4'h3, 1'b0, 1'b0, 1, cyc);

    // 3: conditional jumps and the remaining legal opcodes
    run_instr(4'h7, 1'b0, 1'b0, 0, cyc);
    run_instr(4'h7, 1'b1, 1'b0, 0, cyc);
    run_instr(4'h8, 1'b0, 1'b1, 0, cyc);
    chk("t3_illegal_quiet", 32'(illegal), 32'd0);
    run_instr(4'h1, 1'b0, 1'b0, 0, cyc);
    run_instr(4'h4, 1'b0, 1'b0, 2, cyc);
    run_instr(4'h6, 1'b0, 1'b0, 0, cyc);
    run_instr(4'hE, 1'b0, 1'b0, 0, cyc);
    resume = 1'b1;  // outside HALT this must do nothing
    run_instr(4'h0, 1'b0, 1'b0, 0, cyc);
    resume = 1'b0;
    chk("t3_retired", 32'(retired), 32'd11);

    // 4: HLT, ten halted cycles, resume pulse -> SYNC -> S0
    ir_op = 4'hF; ack_delay = 0;
    gen_instr(4'hF, 1'b0, 1'b0, 0);
    for (int i = 0; i < 10; i++) push(16'h0, 1'b0, 1'b1, 1'b1, 3, 1'b0, 1'b0);
    push(16'h0, 1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b0);
    repeat (12) @(posedge clk);
    #1 resume = 1'b1;
    @(posedge clk);
    #1 resume = 1'b0;
    wait_drain(cyc);
    chk("t4_retired", 32'(retired), 32'd12);
    chk("t4_halted",  32'(halted),  32'd0);
    chk("t4_step",    32'(step),    32'd0);

    // 5: undefined opcodes retire as NOP and pulse illegal
    for (int op = 9; op <= 13; op++) begin
      run_instr(4'(op), 1'b0, 1'b0, 0, cyc);
      chk("t5_illegal_pulse", 32'(illegal), 32'd1);
    end
    chk("t5_retired", 32'(retired), 32'd17);

    // 6: reset while STA is stalled on its write
    ir_op = 4'h4; ack_delay = 0; block_wr = 1'b1;
    push(B_PC_OUT | B_MAR_LD, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    push(B_MEM_RD | B_IR_LD | B_PC_INC, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    push(B_IMM_OUT | B_MAR_LD, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) push(B_A_OUT | B_MEM_WR, 1'b0, 1'b1, 1'b0, 3, 1'b0, 1'b0);
    wait_drain(cyc);
    chk("t6_pre_mem_req", 32'(mem_req),   32'd1);
    chk("t6_pre_hold",    32'(step_hold), 32'd1);
    rst = 1'b0;
    #1;
    chk("t6_mem_req",   32'(mem_req),   32'd0);
    chk("t6_ctrl",      32'(ctrl),      32'd0);
    chk("t6_step_hold", 32'(step_hold), 32'd0);
    chk("t6_step_clr",  32'(step_clr),  32'd1);
    chk("t6_retired",   32'(retired),   32'd0);
    m_ret = 16'h0; ill_exp = 1'b0; block_wr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    push(16'h0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_instr(4'h0, 1'b0, 1'b0, 0, cyc);
    chk("t6_after_retired", 32'(retired), 32'd1);

    // 7: counter wrap from FFFF
    force dut.retired_q = 16'hFFFF;
    #1 release dut.retired_q;
    m_ret = 16'hFFFF;
    gen_instr(4'h0, 1'b0, 1'b0, 0);
    wait_drain(cyc);
    chk("t7_wrap", 32'(retired), 32'h0);
    run_instr(4'h5, 1'b0, 1'b0, 0, cyc);
    chk("t7_after_wrap", 32'(retired), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
